// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//   Registered ALU between operand-fetch and writeback. Takes one operation
//   per valid/ready handshake and returns a registered result with flags.
//   Single-cycle ops (add/sub family, logic, NOT, NEG, illegal opcodes) have
//   a latency of one cycle. MUL is an unsigned shift-add multiply that takes
//   exactly WIDTH cycles from accept to out_valid. While it runs, in_ready
//   is held low.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 4)
//   CNT_W      multiply step-counter width, 2**CNT_W > WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   opcode/a/b are valid this cycle
//   in_ready   block can accept an operation this cycle
//   opcode     5-bit operation select
//   a, b       operands (b unused by NOT/NEG)
//   out_valid  out/out_hi/flags/err hold a result
//   out_ready  consumer takes the result this cycle
//   out        result (low half for MUL)
//   out_hi     upper half of the MUL product, 0 for every other op
//   flag_z     out == 0 (cleared for illegal opcodes)
//   flag_n     out[WIDTH-1]
//   flag_c     carry (ADD/ADC), NOT borrow (SUB/SBB), out_hi != 0 (MUL)
//   flag_v     signed overflow of the add/sub family
//   err        opcode was illegal, out forced to 0
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SBB  = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_NAND = 5'd11;
  localparam logic [4:0] OP_NOR  = 5'd12;
  localparam logic [4:0] OP_XNOR = 5'd13;
  localparam logic [4:0] OP_NOT  = 5'd14;
  localparam logic [4:0] OP_NEG  = 5'd15;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

  state_t state;
  state_t state_next;

  // Carry register shared by the ADC/SBB chain.
  logic carry;

  // Multiplier working registers. The multiplicand shifts left and the
  // multiplier shifts right each step, so step k tests bit k of b and adds
  // a<<k without any variable bit-select.
  logic [2*WIDTH-1:0] ma_sh;
  logic [WIDTH-1:0]   mb_sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]   cnt;

  logic accept;
  logic capture_single;
  logic capture_mul;

  // Single-cycle datapath results.
  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             add_v;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic             res_err;
  logic             res_arith;

  // Handshake: the block only takes new work when idle and the output
  // register is either empty or being emptied on this same edge.
  assign in_ready       = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept         = in_valid && in_ready;
  assign capture_single = accept && (opcode != OP_MUL);
  assign capture_mul    = (state == ST_MUL) && (cnt == LAST_STEP);

  // Add/sub family share one WIDTH+1 adder. opcode[1] selects inverted b
  // (SUB/SBB); opcode[0] selects the carry register as carry-in (ADC/SBB),
  // otherwise SUB gets +1 and ADD gets 0.
  always_comb begin
    b_op  = opcode[1] ? ~b : b;
    cin   = opcode[0] ? carry : opcode[1];
    sum   = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    add_v = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Result selection for every op that completes in one cycle. Illegal
  // opcodes (including the reserved float slots) yield zero with err set.
  always_comb begin
    res       = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    res_err   = 1'b0;
    res_arith = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
        res       = sum[WIDTH-1:0];
        res_c     = sum[WIDTH];
        res_v     = add_v;
        res_arith = 1'b1;
      end
      OP_MUL: begin
        res = '0;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      // NEG wraps naturally: 0 stays 0 and the most-negative value maps to
      // itself. No overflow or carry is reported.
      OP_NEG:  res = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
      default: res_err = 1'b1;
    endcase
  end

  // One multiply step: conditionally add the shifted multiplicand.
  always_comb begin
    acc_next = acc + (mb_sh[0] ? ma_sh : '0);
  end

  // Next-state logic. MUL is entered on accept and left on its final step.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && opcode == OP_MUL) state_next = ST_MUL;
      ST_MUL:  if (cnt == LAST_STEP)           state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register. Reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Multiplier registers: loaded on accept, stepped every MUL cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_sh <= '0;
      mb_sh <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == ST_IDLE) begin
      if (accept && opcode == OP_MUL) begin
        ma_sh <= {{WIDTH{1'b0}}, a};
        mb_sh <= b;
        acc   <= '0;
        cnt   <= '0;
      end
    end else begin
      acc   <= acc_next;
      ma_sh <= ma_sh << 1;
      mb_sh <= mb_sh >> 1;
      cnt   <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Output register and carry register. A capture always wins over a
  // drain, which lets drain and accept share a cycle. Without a capture the
  // result fields hold their value, so they stay stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_hi    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
      carry     <= 1'b0;
    end else if (capture_single) begin
      out_valid <= 1'b1;
      out       <= res;
      out_hi    <= '0;
      flag_z    <= !res_err && (res == '0);
      flag_n    <= res[WIDTH-1];
      flag_c    <= res_c;
      flag_v    <= res_v;
      err       <= res_err;
      if (res_arith) carry <= res_c;
    end else if (capture_mul) begin
      out_valid <= 1'b1;
      out       <= acc_next[WIDTH-1:0];
      out_hi    <= acc_next[2*WIDTH-1:WIDTH];
      flag_z    <= (acc_next[WIDTH-1:0] == '0);
      flag_n    <= acc_next[WIDTH-1];
      flag_c    <= |acc_next[2*WIDTH-1:WIDTH];
      flag_v    <= 1'b0;
      err       <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
//   Scoreboard bench for alu_pipe. The stimulus process pushes the expected
//   response of each accepted operation into a queue. A monitor pops and
//   compares whenever a result is handed over (out_valid && out_ready).
//   Expected flags are packed as {z, n, c, v, err}.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [31:0] out_hi;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_v;
  logic        err;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [4:0]  flags;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  alu_pipe #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string name, input logic [79:0] got,
                             input logic [79:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Drive one operation at a negedge, hold it until in_ready, record the
  // expectation and release in_valid just after the accepting edge.
  task automatic applyStimulus(input string name, input logic [4:0] op,
                               input logic [31:0] va, input logic [31:0] vb,
                               input logic [31:0] elo, input logic [31:0] ehi,
                               input logic [4:0] eflags, input bit push,
                               output int waits);
    exp_t e;
    @(negedge clk);
    opcode   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    waits    = 0;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout %s: got in_ready=0 want 1", name);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.name  = name;
      e.lo    = elo;
      e.hi    = ehi;
      e.flags = eflags;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drainQueue();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
  endtask

  // Monitor: every result handed to the consumer must match the oldest
  // expectation; a result with nothing expected is itself a failure.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got out=%0h want no result", out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput(e.name,
                    {11'd0, out_hi, out, flag_z, flag_n, flag_c, flag_v, err},
                    {11'd0, e.hi, e.lo, e.flags});
      end
    end
  end

  initial begin
    int w;
    int lat;
    int ready_seen;
    int valid_seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    opcode    = 5'd0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", {79'd0, out_valid}, 80'd0);
    checkOutput("reset_outputs",
                {11'd0, out_hi, out, flag_z, flag_n, flag_c, flag_v, err}, 80'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", {79'd0, in_ready}, 80'd1);
    out_ready = 1'b1;

    // Carry chain: ADD sets C, ADC consumes it on the very next cycle.
    applyStimulus("add_wrap", 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'b10100, 1, w);
    checkOutput("add_latency1", {79'd0, out_valid}, 80'd1);
    applyStimulus("adc_chain", 5'd1, 32'h0, 32'h0, 32'h1, 32'h0, 5'b00000, 1, w);
    applyStimulus("sub_borrow", 5'd2, 32'h5, 32'h7, 32'hFFFFFFFE, 32'h0, 5'b01000, 1, w);
    applyStimulus("sbb_c0", 5'd3, 32'h10, 32'h0, 32'hF, 32'h0, 5'b00100, 1, w);
    applyStimulus("add_ovf", 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 5'b01010, 1, w);

    // Logic and unary ops.
    applyStimulus("and", 5'd8, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 5'b01000, 1, w);
    applyStimulus("or", 5'd9, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0, 5'b01000, 1, w);
    applyStimulus("xor", 5'd10, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 5'b00000, 1, w);
    applyStimulus("nand", 5'd11, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 32'h0, 5'b00000, 1, w);
    applyStimulus("nor", 5'd12, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'h0, 5'b00000, 1, w);
    applyStimulus("xnor", 5'd13, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 32'h0, 5'b01000, 1, w);
    applyStimulus("not", 5'd14, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 5'b00000, 1, w);
    applyStimulus("neg1", 5'd15, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h0, 5'b01000, 1, w);
    applyStimulus("neg0", 5'd15, 32'h0, 32'h0, 32'h0, 32'h0, 5'b10000, 1, w);
    applyStimulus("neg_min", 5'd15, 32'h80000000, 32'h0, 32'h80000000, 32'h0, 5'b01000, 1, w);

    // Multiply: exactly 32 cycles from accept, in_ready low all along.
    applyStimulus("mul_ff_2", 5'd4, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 5'b01100, 1, w);
    checkOutput("mul_in_ready_at_accept", {79'd0, in_ready}, 80'd0);
    lat = 0;
    ready_seen = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid && in_ready) ready_seen++;
    end
    checkOutput("mul_latency", 80'(lat), 80'd32);
    checkOutput("mul_in_ready_low", 80'(ready_seen), 80'd0);
    applyStimulus("mul_shift", 5'd4, 32'h12345678, 32'h10, 32'h23456780, 32'h1, 5'b00100, 1, w);
    applyStimulus("mul_small", 5'd4, 32'h3, 32'h5, 32'hF, 32'h0, 5'b00000, 1, w);
    drainQueue();

    // Backpressure: result held stable, then drain and accept together.
    out_ready = 1'b0;
    applyStimulus("bp_add", 5'd0, 32'h1, 32'h2, 32'h3, 32'h0, 5'b00000, 1, w);
    checkOutput("bp_out_valid", {79'd0, out_valid}, 80'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", {79'd0, in_ready}, 80'd0);
      checkOutput("bp_out_stable",
                  {11'd0, out_hi, out, flag_z, flag_n, flag_c, flag_v, err, out_valid},
                  {11'd0, 32'h0, 32'h3, 5'b00000, 1'b1});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus("bp_and", 5'd8, 32'hFF, 32'h0F, 32'hF, 32'h0, 5'b00000, 1, w);
    checkOutput("drain_accept_same_cycle", 80'(w), 80'd0);
    checkOutput("new_result_after_drain", {47'd0, out_valid, out}, {47'd0, 1'b1, 32'hF});

    // Illegal opcodes leave C untouched.
    applyStimulus("set_c", 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'b10100, 1, w);
    applyStimulus("illegal6", 5'd6, 32'h1234, 32'h5678, 32'h0, 32'h0, 5'b00001, 1, w);
    applyStimulus("adc_c_kept", 5'd1, 32'h0, 32'h0, 32'h1, 32'h0, 5'b00000, 1, w);
    applyStimulus("illegal20", 5'd20, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 5'b00001, 1, w);
    applyStimulus("adc_c0_kept", 5'd1, 32'h0, 32'h0, 32'h0, 32'h0, 5'b10000, 1, w);

    // Reset during a multiply: no result, ready right away, C cleared.
    applyStimulus("set_c2", 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 5'b10100, 1, w);
    drainQueue();
    applyStimulus("mul_aborted", 5'd4, 32'h3, 32'h3, 32'h0, 32'h0, 5'b00000, 0, w);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_mul_in_ready", {79'd0, in_ready}, 80'd1);
    checkOutput("rst_mid_mul_out_valid", {79'd0, out_valid}, 80'd0);
    valid_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) valid_seen++;
    end
    checkOutput("rst_mid_mul_no_result", 80'(valid_seen), 80'd0);
    applyStimulus("adc_after_rst", 5'd1, 32'h2, 32'h3, 32'h5, 32'h0, 5'b00000, 1, w);

    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checkOutput("scoreboard_drained", 80'(sb.size()), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
